// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: word-serial front/back end for the 128x128 shift-add multiplier.
// Gathers two OPW-bit operands from a DW-bit valid/ready stream, launches the
// multiplier, captures its 2*OPW-bit product and streams it out LS word first.
// Optional feature macro: MUL_TIMEOUT_EN (abort a RUN that exceeds TIMEOUT cycles).
module mul_seq_ctrl #(
   parameter int DW      = 32,
   parameter int OPW     = 128,
   parameter int TIMEOUT = 300
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic             out_last,
   output logic             mul_start,
   output logic [OPW-1:0]   mul_ain,
   output logic [OPW-1:0]   mul_bin,
   input  logic [2*OPW-1:0] mul_yout,
   input  logic             mul_done,
   output logic             busy,
   output logic             err
);

   // Words per operand; the product has the same word count as both operands together.
   localparam int NW = OPW / DW;
   localparam int TW = 2 * NW;
   localparam int CW = (TW > 1) ? $clog2(TW) : 1;
   localparam logic [CW-1:0] LASTW = CW'(TW - 1);
   localparam logic [CW-1:0] NW_C  = CW'(NW);

   typedef enum logic [1:0] {
      ST_LOAD = 2'b00,
      ST_RUN  = 2'b01,
      ST_OUT  = 2'b10
   } state_t;

   state_t           state_r, state_nx;
   logic [CW-1:0]    cnt_r, cnt_nx;     // input word index in LOAD, output word index in OUT
   logic             pend_r, pend_nx;   // operands complete, launch held off by a stale mul_done
   logic [2*OPW-1:0] prod_r, prod_nx;
   logic [OPW-1:0]   ain_nx, bin_nx;
   logic [CW-1:0]    slot_s;
   logic             in_ready_nx, out_valid_nx, out_last_nx, mul_start_nx, busy_nx;
   logic [DW-1:0]    out_data_nx;

`ifdef MUL_TIMEOUT_EN
   localparam int TMW = $clog2(TIMEOUT + 1);
   logic [TMW-1:0] timer_r, timer_nx;
   logic           err_r, err_nx;
   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   // Next-state, operand/product update and next-output decode.
   always_comb begin
      state_nx = state_r;
      cnt_nx   = cnt_r;
      pend_nx  = pend_r;
      prod_nx  = prod_r;
      ain_nx   = mul_ain;
      bin_nx   = mul_bin;
      slot_s   = {CW{1'b0}};
`ifdef MUL_TIMEOUT_EN
      timer_nx = timer_r;
      err_nx   = err_r;
`endif
      case (state_r)
         ST_LOAD: begin
`ifdef MUL_TIMEOUT_EN
            timer_nx = {TMW{1'b0}};
`endif
            if (pend_r) begin
               // Launch only once the previous done has been withdrawn.
               if (!mul_done) begin
                  pend_nx  = 1'b0;
                  state_nx = ST_RUN;
               end else begin
                  pend_nx  = 1'b1;
               end
            end else if (in_valid && in_ready) begin
               if (cnt_r < NW_C) begin
                  slot_s = cnt_r;
                  ain_nx[slot_s*DW +: DW] = in_data;
               end else begin
                  slot_s = cnt_r - NW_C;
                  bin_nx[slot_s*DW +: DW] = in_data;
               end
               if (cnt_r == LASTW) begin
                  cnt_nx = {CW{1'b0}};
                  if (mul_done) begin
                     pend_nx  = 1'b1;
                  end else begin
                     state_nx = ST_RUN;
                  end
               end else begin
                  cnt_nx = cnt_r + CW'(1);
               end
            end else begin
               state_nx = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (mul_done) begin
               prod_nx  = mul_yout;
               cnt_nx   = {CW{1'b0}};
               state_nx = ST_OUT;
`ifdef MUL_TIMEOUT_EN
            end else if (timer_r == TMW'(TIMEOUT - 1)) begin
               // Abort with a recognisable all-ones product so the stream drains.
               err_nx   = 1'b1;
               prod_nx  = {(2*OPW){1'b1}};
               cnt_nx   = {CW{1'b0}};
               state_nx = ST_OUT;
            end else begin
               timer_nx = timer_r + TMW'(1);
`else
            end else begin
               state_nx = ST_RUN;
`endif
            end
         end
         ST_OUT: begin
            if (out_valid && out_ready) begin
               if (cnt_r == LASTW) begin
                  cnt_nx   = {CW{1'b0}};
                  state_nx = ST_LOAD;
               end else begin
                  cnt_nx   = cnt_r + CW'(1);
               end
            end else begin
               state_nx = ST_OUT;
            end
         end
         default: begin
            state_nx = ST_LOAD;
            cnt_nx   = {CW{1'b0}};
            pend_nx  = 1'b0;
         end
      endcase

      in_ready_nx  = (state_nx == ST_LOAD) && !pend_nx;
      out_valid_nx = (state_nx == ST_OUT);
      out_last_nx  = (state_nx == ST_OUT) && (cnt_nx == LASTW);
      mul_start_nx = (state_nx == ST_RUN);
      busy_nx      = !((state_nx == ST_LOAD) && (cnt_nx == {CW{1'b0}}) && !pend_nx);
      out_data_nx  = prod_nx[cnt_nx*DW +: DW];
   end

   // State, data and output registers; rst clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_LOAD;
         cnt_r     <= {CW{1'b0}};
         pend_r    <= 1'b0;
         prod_r    <= {(2*OPW){1'b0}};
         mul_ain   <= {OPW{1'b0}};
         mul_bin   <= {OPW{1'b0}};
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         mul_start <= 1'b0;
         busy      <= 1'b0;
         out_data  <= {DW{1'b0}};
      end else begin
         state_r   <= state_nx;
         cnt_r     <= cnt_nx;
         pend_r    <= pend_nx;
         prod_r    <= prod_nx;
         mul_ain   <= ain_nx;
         mul_bin   <= bin_nx;
         in_ready  <= in_ready_nx;
         out_valid <= out_valid_nx;
         out_last  <= out_last_nx;
         mul_start <= mul_start_nx;
         busy      <= busy_nx;
         out_data  <= out_data_nx;
      end
   end

`ifdef MUL_TIMEOUT_EN
   // RUN cycle counter and sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_r <= {TMW{1'b0}};
         err_r   <= 1'b0;
      end else begin
         timer_r <= timer_nx;
         err_r   <= err_nx;
      end
   end
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with a behavioural multiplier model.
module tb_mul_seq_ctrl;
   localparam int DW  = 32;
   localparam int OPW = 128;
   localparam int LAT = 5;    // model: done appears LAT+1 cycles after start is seen
   localparam int TMO = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready;
   logic [DW-1:0]    in_data;
   logic             out_valid, out_ready, out_last;
   logic [DW-1:0]    out_data;
   logic             mul_start, mul_done, busy, err;
   logic [OPW-1:0]   mul_ain, mul_bin;
   logic [2*OPW-1:0] mul_yout;

   int n_checks = 0;
   int n_fail   = 0;

   logic             done_force, done_dis;
   logic             m_done;
   int               m_cnt;
   logic [2*OPW-1:0] m_yout;

   mul_seq_ctrl #(.DW(DW), .OPW(OPW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .mul_start(mul_start), .mul_ain(mul_ain), .mul_bin(mul_bin),
      .mul_yout(mul_yout), .mul_done(mul_done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural multiplier: after start has been high LAT+1 edges, done rises with a*b.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
         m_yout <= '0;
      end else if (mul_start && !done_dis) begin
         if (m_cnt == LAT) begin
            m_done <= 1'b1;
            m_yout <= {128'd0, mul_ain} * {128'd0, mul_bin};
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end else begin
         m_cnt  <= 0;
         m_done <= 1'b0;
      end
   end
   assign mul_done = m_done | done_force;
   assign mul_yout = m_yout;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [255:0] ref_prod(input logic [127:0] a, input logic [127:0] b);
      return {128'd0, a} * {128'd0, b};
   endfunction

   // Send the first n words of the a-then-b word sequence.
   task automatic send_ops(input logic [127:0] a, input logic [127:0] b, input bit gaps, input int n);
      logic [255:0] words;
      int bud;
      words = {b, a};
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         in_valid = 1'b1;
         in_data  = words[i*32 +: 32];
         bud = 0;
         @(negedge clk);
         while (!in_ready && bud < 50) begin @(negedge clk); bud++; end
         if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL in_wait word %0d: in_ready=%b, expected 1 within 50 cycles", i, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // Collect 8 product words; mode 0 always ready, 1 pattern 1,0,0,..., 2 random.
   task automatic collect(input logic [255:0] exp, input int mode, input string nm,
                          input int exp_starts, input logic exp_err);
      int k, cyc, c, starts;
      bit seen, stalled, rdy;
      logic [31:0] prev;
      k = 0; cyc = 0; c = 0; starts = 0; seen = 0; stalled = 0; prev = '0;
      out_ready = 1'b1;
      while (k < 8 && cyc < 600) begin
         @(negedge clk); cyc++;
         if (!out_valid) begin
            if (mul_start) starts++;
         end else begin
            if (!seen) begin
               seen = 1;
               n_checks++;
               if (starts !== exp_starts) begin n_fail++;
                  $display("FAIL %s start_window: got %0d cycles, expected %0d", nm, starts, exp_starts); end
               n_checks++;
               if ({mul_start, busy, err} !== {1'b0, 1'b1, exp_err}) begin n_fail++;
                  $display("FAIL %s first_out start/busy/err: got %b%b%b, expected 0 1 %b", nm, mul_start, busy, err, exp_err); end
            end
            if (stalled) begin
               n_checks++;
               if (out_data !== prev) begin n_fail++;
                  $display("FAIL %s stall_hold word %0d: got %h, expected %h", nm, k, out_data, prev); end
            end
            n_checks++;
            if (out_data !== exp[k*32 +: 32]) begin n_fail++;
               $display("FAIL %s word %0d: got %h, expected %h", nm, k, out_data, exp[k*32 +: 32]); end
            n_checks++;
            if (out_last !== (k == 7)) begin n_fail++;
               $display("FAIL %s last word %0d: got %b, expected %b", nm, k, out_last, (k == 7)); end
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = (c % 3 == 0);
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            c++;
            out_ready = rdy;
            stalled   = !rdy;
            prev      = out_data;
            if (rdy) k++;
         end
      end
      if (k < 8) begin
         n_checks++; n_fail++;
         $display("FAIL %s out_wait: got %0d words, expected 8", nm, k);
      end
      @(negedge clk);
      out_ready = 1'b1;
      n_checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++;
         $display("FAIL %s back_to_load valid/ready/busy: got %b%b%b, expected 010", nm, out_valid, in_ready, busy); end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_last, mul_start, busy, err, mul_ain, mul_bin, out_data} !==
          {1'b1, 5'b0, 128'd0, 128'd0, 32'd0}) begin n_fail++;
         $display("FAIL reset_state: got rdy=%b v=%b l=%b st=%b busy=%b err=%b, expected 1 0 0 0 0 0 and zero data",
                  in_ready, out_valid, out_last, mul_start, busy, err); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      send_ops(128'd3, 128'd5, 1'b0, 8);
      collect(ref_prod(128'd3, 128'd5), 0, "basic_3x5", LAT + 2, 1'b0);
      send_ops({128{1'b1}}, {128{1'b1}}, 1'b0, 8);
      collect({{96{1'b1}}, 32'hFFFFFFFE, 96'd0, 32'd1}, 0, "all_ones", LAT + 2, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [255:0] e;
      e = ref_prod(128'h1_0000_0000, 128'd2);
      n_checks++;
      if (e !== {192'd0, 32'd2, 32'd0}) begin n_fail++;
         $display("FAIL bp_model: got %h, expected word1=2", e); end
      send_ops(128'h1_0000_0000, 128'd2, 1'b0, 8);
      collect(e, 1, "backpressure", LAT + 2, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [127:0] a, b;
      send_ops({4{32'hDEADBEEF}}, {4{32'h12345678}}, 1'b0, 5);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++;
         $display("FAIL mid_busy: got %b, expected 1", busy); end
      rst = 1'b1; #1;
      n_checks++;
      if ({in_ready, out_valid, out_last, mul_start, busy, mul_ain, mul_bin} !== {1'b1, 4'b0, 128'd0, 128'd0}) begin
         n_fail++;
         $display("FAIL rst_mid_load: got rdy=%b v=%b st=%b busy=%b, expected 1 0 0 0 zero operands",
                  in_ready, out_valid, mul_start, busy); end
      @(negedge clk); rst = 1'b0;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      send_ops(a, b, 1'b0, 8);
      collect(ref_prod(a, b), 0, "fresh_after_rst", LAT + 2, 1'b0);
      // Reset in the middle of RUN: start must fall without waiting for a clock.
      send_ops(a, b, 1'b0, 8);
      @(negedge clk); @(negedge clk);
      n_checks++;
      if (mul_start !== 1'b1) begin n_fail++;
         $display("FAIL run_start: got %b, expected 1", mul_start); end
      #2 rst = 1'b1; #1;
      n_checks++;
      if ({mul_start, out_valid, in_ready, busy} !== 4'b0010) begin n_fail++;
         $display("FAIL rst_mid_run: got st/v/rdy/busy %b%b%b%b, expected 0010", mul_start, out_valid, in_ready, busy); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_done_hold();
      logic [127:0] a, b;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {96'd0, $urandom};
      done_force = 1'b1;
      send_ops(a, b, 1'b0, 8);
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if ({mul_start, in_ready, out_valid} !== 3'b000) begin n_fail++;
            $display("FAIL done_hold: got start/rdy/valid %b%b%b, expected 000", mul_start, in_ready, out_valid); end
      end
      done_force = 1'b0;
      collect(ref_prod(a, b), 0, "after_done_hold", LAT + 2, 1'b0);
   endtask

   task automatic test_random();
      logic [127:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = {$urandom, $urandom, $urandom, $urandom};
         b = {$urandom, $urandom, $urandom, $urandom};
         if (i == 1) b = '0;
         send_ops(a, b, 1'b1, 8);
         collect(ref_prod(a, b), int'($urandom_range(0, 2)), "random", LAT + 2, 1'b0);
      end
   endtask

   task automatic test_timeout();
`ifdef MUL_TIMEOUT_EN
      done_dis = 1'b1;
      send_ops(128'd7, 128'd9, 1'b0, 8);
      collect({256{1'b1}}, 0, "timeout", TMO, 1'b1);
      done_dis = 1'b0;
      n_checks++;
      if (err !== 1'b1) begin n_fail++;
         $display("FAIL err_sticky: got %b, expected 1", err); end
      rst = 1'b1; #1;
      n_checks++;
      if (err !== 1'b0) begin n_fail++;
         $display("FAIL err_clear: got %b, expected 0", err); end
      @(negedge clk); rst = 1'b0;
`else
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0) begin n_fail++;
         $display("FAIL err_tied: got %b, expected 0", err); end
`endif
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      done_force = 1'b0; done_dis = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_mid();
      test_done_hold();
      test_random();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
